// File: rtl/chess_pkg.sv
// -----------------------------------------------------------------------------
// chess_pkg
// Shared board encoding for the move-generation pipeline.
//   - colour constants (WHITE/BLACK)
//   - 5-bit piece type codes; a square is {colour, type[4:0]}
//   - SQ_LAST, the highest square index
//   - piece_scanner state codes and the matching state enum
//   - is_engine_piece(): does a board word hold a piece of the given colour
// -----------------------------------------------------------------------------
package chess_pkg;

    localparam logic WHITE = 1'b1;
    localparam logic BLACK = 1'b0;

    localparam logic [4:0] EMPTY  = 5'b00000;
    localparam logic [4:0] PAWN   = 5'b00010;
    localparam logic [4:0] KNIGHT = 5'b00001;
    localparam logic [4:0] BISHOP = 5'b01000;
    localparam logic [4:0] ROOK   = 5'b10000;
    localparam logic [4:0] QUEEN  = 5'b11000;
    localparam logic [4:0] KING   = 5'b00100;

    localparam logic [5:0] SQ_LAST = 6'd63;

    // Plain constants so the state register stays a bare logic vector.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_EMIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        SCAN_IDLE  = ST_IDLE,
        SCAN_FETCH = ST_FETCH,
        SCAN_CHECK = ST_CHECK,
        SCAN_EMIT  = ST_EMIT,
        SCAN_DONE  = ST_DONE
    } scan_state_e;

    // Type codes are not validated: any non-zero type is a piece.
    function automatic logic is_engine_piece(input logic [5:0] sq, input logic color);
        return (sq[4:0] != EMPTY) && (sq[5] == color);
    endfunction

endpackage

// File: rtl/piece_scanner_if.sv
// -----------------------------------------------------------------------------
// piece_scanner_if
// Valid/ready handshake carrying one piece from the scanner to the Transmitter.
//   piece_reg   {colour, type} of the emitted piece
//   pos_reg     square index of the emitted piece
//   piece_valid piece_reg/pos_reg are valid
//   piece_ready consumer accepts
// master = scanner side, slave = consumer side.
// -----------------------------------------------------------------------------
interface piece_scanner_if;

    logic [5:0] piece_reg;
    logic [5:0] pos_reg;
    logic       piece_valid;
    logic       piece_ready;

    modport master (
        output piece_reg,
        output pos_reg,
        output piece_valid,
        input  piece_ready
    );

    modport slave (
        input  piece_reg,
        input  pos_reg,
        input  piece_valid,
        output piece_ready
    );

endinterface

// File: rtl/piece_scanner.sv
// -----------------------------------------------------------------------------
// piece_scanner
// Walks the 64-square board RAM from square 0 to 63 after a start request and
// presents every square holding a piece of the engine's colour on the
// piece handshake.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   start             one-cycle scan request, honoured only when idle
//   engine_color      colour to scan for, sampled with an accepted start
//   board_addr        square index to the board RAM
//   board_data        board RAM word, valid one cycle after board_addr
//   pif               piece handshake (master side)
//   busy              scan in progress (FETCH/CHECK/EMIT)
//   done              one-cycle pulse when a scan finishes
//   piece_count       pieces emitted in the current/last scan
// -----------------------------------------------------------------------------
module piece_scanner
    import chess_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   engine_color,
    output logic [5:0]             board_addr,
    input  logic [5:0]             board_data,
    piece_scanner_if.master        pif,
    output logic                   busy,
    output logic                   done,
    output logic [6:0]             piece_count
);

    logic [2:0] state_q, state_d;
    logic [5:0] addr_q,  addr_d;
    logic       color_q, color_d;
    logic [5:0] piece_q, piece_d;
    logic [5:0] pos_q,   pos_d;
    logic       valid_q, valid_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;
    logic [6:0] count_q, count_d;

    // Next-state logic. busy and done are computed one cycle early so they
    // can be registered alongside the state they describe.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        color_d = color_q;
        piece_d = piece_q;
        pos_d   = pos_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        count_d = count_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    color_d = engine_color;
                    count_d = 7'd0;
                    addr_d  = 6'd0;
                    busy_d  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (is_engine_piece(board_data, color_q)) begin
                    piece_d = board_data;
                    pos_d   = addr_q;
                    valid_d = 1'b1;
                    state_d = ST_EMIT;
                end else if (addr_q == SQ_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + 6'd1;
                    state_d = ST_FETCH;
                end
            end
            ST_EMIT: begin
                if (pif.piece_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + 7'd1;
                    if (pos_q == SQ_LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + 6'd1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any scan without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 6'd0;
            color_q <= 1'b0;
            piece_q <= 6'd0;
            pos_q   <= 6'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= 7'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            color_q <= color_d;
            piece_q <= piece_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign board_addr      = addr_q;
    assign pif.piece_reg   = piece_q;
    assign pif.pos_reg     = pos_q;
    assign pif.piece_valid = valid_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign piece_count     = count_q;

endmodule

// File: doc/piece_scanner.md
# piece_scanner

Upstream feeder for the Transmitter stage. After `start`, it walks the 64-square board memory in ascending order from square 0 to square 63. Each square holding a piece of the engine's colour is presented as a `piece_reg`/`pos_reg` pair on a valid/ready handshake. Downstream logic drives `engine_color`, `piece_reg` and `pos_reg` of the Transmitter directly from these outputs and returns `piece_ready` once it has consumed the 16 ray/knight outputs.

## Interface

Parameters:
- none. Board size (64) and encoding widths are fixed by the shared package.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a scan. Ignored unless the state is IDLE.
- `engine_color`  in  1  colour to scan for (1 = WHITE, 0 = BLACK). Sampled on the accepted `start`.
- `board_addr`  out  6  square index to the board RAM.
- `board_data`  in  6  board RAM contents {colour, type[4:0]}. Registered read: valid one cycle after `board_addr`.
- `piece_reg`  out  6  {colour, type} of the emitted piece.
- `pos_reg`  out  6  square index of the emitted piece.
- `piece_valid`  out  1  `piece_reg`/`pos_reg` valid.
- `piece_ready`  in  1  consumer accepts.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  one-cycle pulse at the end of a scan.
- `piece_count`  out  7  pieces emitted in the current/last scan (0..64).

## Operation

States are IDLE, FETCH, CHECK, EMIT, DONE.
- **IDLE**
  - On `start`=1: latch `engine_color`, clear `piece_count`, set `board_addr`=0, go to FETCH.
- **FETCH**
  - `board_addr` is stable. Go to CHECK next cycle.
- **CHECK**
  - `board_data` is valid for `board_addr`.
  - Match condition: `type` != 5'b00000 and `board_data[5]` == latched colour.
  - Match: register `piece_reg`=`board_data`, `pos_reg`=`board_addr`, `piece_valid`=1, go to EMIT.
  - No match, `board_addr`==63: go to DONE.
  - No match, `board_addr`<63: increment `board_addr`, go to FETCH.
- **EMIT**
  - Transfer happens on a rising edge with `piece_valid` && `piece_ready`.
  - `piece_reg`, `pos_reg` and `piece_valid` are held stable until the transfer.
  - On transfer: `piece_valid`=0, `piece_count`+1, then go to DONE if `pos_reg`==63, else increment `board_addr` and go to FETCH.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE. `start` is ignored here.

General rules:
- `busy`=1 in FETCH, CHECK and EMIT only.
- Type codes are not validated. Any non-zero type counts as a piece.
- `piece_count` keeps its value after DONE until the next accepted `start`.

## Timing

- Reset: state IDLE; `board_addr`, `piece_reg`, `pos_reg` = 0; `piece_valid`, `busy`, `done` = 0; `piece_count` = 0. Async assertion aborts any scan immediately; no `done` is produced.
- Call the edge that samples `start` E0. FETCH for square 0 occupies E0→E1.
- Each non-emitting square costs 2 cycles. Each emitting square costs 2 + k cycles, where k ≥ 1 is the number of EMIT cycles.
- Empty board: `done` is high in the cycle following edge E128. The state is IDLE after E129.
- The earliest possible `piece_valid` is the cycle after E2 (square 0 matching).
- All outputs are registered. There is no combinational path from `piece_ready` or `board_data` to any output.

## Structure

- Shared package `chess_pkg` holds:
  - WHITE=1, BLACK=0.
  - EMPTY=5'b00000, PAWN=5'b00010, KNIGHT=5'b00001, BISHOP=5'b01000, ROOK=5'b10000, QUEEN=5'b11000, KING=5'b00100.
  - SQ_LAST=6'd63.
  - The scanner state enum.
- Single module; no sub-module needed. The bench models the board RAM as a 64×6 registered-read array.

## Test plan

- **Empty board:** all squares 6'b000000, `start` at E0, `piece_ready`=1 → `piece_valid` never asserts; `done` in the cycle after E128; `piece_count`=0.
- **Colour filter:** square 2 = 6'b100010 (white pawn), square 10 = 6'b000001 (black knight), `engine_color`=1 → exactly one transfer with `piece_reg`=100010, `pos_reg`=000010; `piece_count`=1; `done` after E129.
- **Backpressure:** as above, with `piece_ready` held low for 5 cycles after `piece_valid` rises → outputs remain stable throughout; exactly one transfer; `done` delayed by 5 cycles.
- **Full side:** white starting position on squares 0–15, black on 48–63, `engine_color`=1 → 16 transfers with `pos_reg` 0..15 in ascending order; `piece_count`=16.
- **Last square:** black king (6'b000100) on square 63, `engine_color`=0 → the transfer at `pos_reg`=63 is followed directly by DONE (no FETCH).
- **Control:**
  - Second `start` while `busy` → ignored; scan unaffected.
  - `reset` asserted mid-EMIT → all outputs zero asynchronously; no `done`.
  - A new `start` after release performs a clean scan.
